// File: rtl/serial_nibble_subtractor.sv
// serial_nibble_subtractor: nibble-serial A - B - borrow_in, LSB slice first; optional signed overflow under SERIAL_SUB_OVERFLOW_EN
module serial_nibble_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  input  logic             i_borrow,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_borrow,
  output logic             o_overflow
);
  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic [4:0]       sum;
  logic             accept, run, last;

  // Operands shift right so the active slice is always in bits [3:0]; the result is written in place
  always_comb begin
    run     = state_q == RUN;
    accept  = !run && i_start;
    last    = run && cnt_q == LAST;
    sum     = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0, ~brw_q};
    state_d = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
    cnt_d   = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    a_d     = accept ? i_minuend : run ? a_q >> 4 : a_q;
    b_d     = accept ? i_subtrahend : run ? b_q >> 4 : b_q;
    brw_d   = accept ? i_borrow : run ? ~sum[4] : brw_q;
    bout_d  = accept ? 1'b0 : last ? ~sum[4] : bout_q;
    res_d   = res_q;
    for (int j = 0; j < N; j++)
      if (run && cnt_q == CW'(j)) res_d[4*j +: 4] = sum[3:0];
    if (accept) res_d = '0;
  end

  // State, datapath and result registers; reset wipes any partial operation
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  assign o_busy   = state_q == RUN;
  assign o_done   = state_q == DONE;
  assign o_result = res_q;
  assign o_borrow = bout_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // On the final slice a_q[3]/b_q[3] are the operand sign bits and sum[3] the result sign
  always_comb ovf_d = accept ? 1'b0 : last ? ((a_q[3] != b_q[3]) && (sum[3] != a_q[3])) : ovf_q;

  // Overflow flag register, held from DONE until the next acceptance
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end

  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// tb_serial_nibble_subtractor: directed self-checking bench for the 16-bit nibble-serial subtractor
module tb_serial_nibble_subtractor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mnd = '0;
  logic [15:0] sub = '0;
  logic        bin = 1'b0;
  logic        busy, done, brw, ovf;
  logic [15:0] res;
  int checks = 0;
  int failures = 0;

`ifdef SERIAL_SUB_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  serial_nibble_subtractor #(.WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_minuend(mnd), .i_subtrahend(sub),
    .i_borrow(bin), .o_busy(busy), .o_done(done), .o_result(res), .o_borrow(brw),
    .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi, output int lat);
    @(negedge clk);
    mnd = a; sub = b; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (res !== 16'h0) begin failures++; $display("FAIL reset_result got=%h exp=0000", res); end
    checks++; if (brw !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b exp=0", brw); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_plain;
    int lat;
    run_op(16'h1234, 16'h0234, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL plain_latency got=%0d exp=4", lat); end
    checks++; if (res !== 16'h1000) begin failures++; $display("FAIL plain_result got=%h exp=1000", res); end
    checks++; if (brw !== 1'b0) begin failures++; $display("FAIL plain_borrow got=%b exp=0", brw); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL plain_overflow got=%b exp=0", ovf); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL plain_busy_in_done got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL plain_done_width got=%b exp=0", done); end
    checks++; if (res !== 16'h1000) begin failures++; $display("FAIL plain_result_hold got=%h exp=1000", res); end
  endtask

  task automatic test_underflow;
    int lat;
    run_op(16'h0000, 16'h0001, 1'b0, lat);
    checks++; if (res !== 16'hFFFF) begin failures++; $display("FAIL underflow_result got=%h exp=ffff", res); end
    checks++; if (brw !== 1'b1) begin failures++; $display("FAIL underflow_borrow got=%b exp=1", brw); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL underflow_overflow got=%b exp=0", ovf); end
  endtask

  task automatic test_borrow_ripple;
    int lat;
    run_op(16'h0010, 16'h0000, 1'b1, lat);
    checks++; if (res !== 16'h000F) begin failures++; $display("FAIL ripple_result got=%h exp=000f", res); end
    checks++; if (brw !== 1'b0) begin failures++; $display("FAIL ripple_borrow got=%b exp=0", brw); end
  endtask

  task automatic test_overflow;
    int lat;
    run_op(16'h8000, 16'h0001, 1'b0, lat);
    checks++; if (res !== 16'h7FFF) begin failures++; $display("FAIL ovf_result got=%h exp=7fff", res); end
    checks++; if (brw !== 1'b0) begin failures++; $display("FAIL ovf_borrow got=%b exp=0", brw); end
    checks++; if (ovf !== OVF_EXP) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", ovf, OVF_EXP); end
    run_op(16'h0003, 16'h0001, 1'b0, lat);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
  endtask

  task automatic test_handshake;
    int ndone = 0;
    logic [15:0] first = '0;
    @(negedge clk);
    mnd = 16'h00FF; sub = 16'h000F; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mnd = 16'hFFFF; sub = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin ndone++; first = res; end
      @(posedge clk); #1;
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL hs_done_count got=%0d exp=1", ndone); end
    checks++; if (first !== 16'h00F0) begin failures++; $display("FAIL hs_result got=%h exp=00f0", first); end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(16'h0050, 16'h0020, 1'b0, lat);
    checks++; if (res !== 16'h0030) begin failures++; $display("FAIL b2b_first got=%h exp=0030", res); end
    mnd = 16'h0100; sub = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    checks++; if (res !== 16'h0000) begin failures++; $display("FAIL b2b_result_cleared got=%h exp=0000", res); end
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    checks++; if (res !== 16'h00FF) begin failures++; $display("FAIL b2b_second got=%h exp=00ff", res); end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    mnd = 16'hFFFF; sub = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (res !== 16'h0) begin failures++; $display("FAIL midrst_result got=%h exp=0000", res); end
    checks++; if (done !== 1'b0 || brw !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL midrst_flags got=%b%b%b exp=000", done, brw, ovf);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0005, 16'h0003, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL midrst_latency got=%0d exp=4", lat); end
    checks++; if (res !== 16'h0002) begin failures++; $display("FAIL midrst_result_after got=%h exp=0002", res); end
    checks++; if (brw !== 1'b0) begin failures++; $display("FAIL midrst_borrow_after got=%b exp=0", brw); end
  endtask

  initial begin
    test_reset;
    test_plain;
    test_underflow;
    test_borrow_ripple;
    test_overflow;
    test_handshake;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_nibble_subtractor.md
# serial_nibble_subtractor

Multi-cycle subtractor computing `i_minuend - i_subtrahend - i_borrow` one 4-bit slice per clock, least-significant nibble first, with the inter-slice borrow held in a register. It is the inverse-direction companion to the team's 4-bit carry-lookahead adder. It reuses the same nibble-wide datapath idea, but trades latency for a single small slice so wide operands fit in minimal logic. A start/busy/done handshake connects it to a controlling sequencer or bench.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  request; sampled on the rising edge when `o_busy` = 0.
- i_minuend  input  WIDTH  operand A; latched on acceptance.
- i_subtrahend  input  WIDTH  operand B; latched on acceptance.
- i_borrow  input  1  borrow-in; latched on acceptance.
- o_busy  output  1  high while slices are being processed.
- o_done  output  1  one-cycle pulse when the result becomes valid.
- o_result  output  WIDTH  A − B − borrow, modulo 2^WIDTH.
- o_borrow  output  1  final borrow-out, meaning the unsigned result was negative.
- o_overflow  output  1  signed two's-complement overflow; see Configuration.

## Operation
- N = WIDTH/4 slices. The design has a slice counter of ceil(log2(N+1)) bits.
- States:
  - IDLE: waiting for a request.
  - RUN: processing slices.
  - DONE: result valid, one cycle only.
- IDLE → RUN when `i_start` = 1. On that edge:
  - latch A, B and `i_borrow`
  - clear the counter
  - clear the result register
- RUN, slice k (k = 0..N-1), on each edge:
  - compute `{c, d} = A[4k+3:4k] + ~B[4k+3:4k] + !borrow_reg` in 5 bits
  - write d into `o_result[4k+3:4k]`
  - set `borrow_reg = !c`
  - increment the counter
- RUN → DONE on the edge that processes slice N-1.
- DONE → RUN if `i_start` = 1, accepted exactly as from IDLE. Otherwise DONE → IDLE.
- `o_busy` = 1 in RUN only. `o_done` = 1 in DONE only.
- `o_result`, `o_borrow` and `o_overflow` hold their values from DONE until the next acceptance edge, when they are cleared.
- `i_start` during RUN is ignored. Operand changes during RUN have no effect.
- `o_overflow` is computed on the final slice as `(A[W-1] != B[W-1]) && (d[3] != A[W-1])`.
- Asynchronous reset, including mid-operation: state = IDLE, counter = 0, and all outputs and internal registers = 0. No partial result survives reset.

## Timing
- Acceptance edge t. `o_busy` is high from t through the edge t+N.
- `o_done` is high for exactly the cycle between edges t+N and t+N+1.
- Latency is N cycles from acceptance to `o_done`: 4 cycles for WIDTH = 16, 1 cycle for WIDTH = 4.
- Back-to-back operation: `i_start` held through the DONE cycle starts the next operation on edge t+N+1. Throughput is one result per N+1 cycles with no idle gap.
- Reset values: `o_busy` = 0, `o_done` = 0, `o_result` = 0, `o_borrow` = 0, `o_overflow` = 0.
- The outputs are registered and have no combinational path from the inputs.

## Configuration
- `SERIAL_SUB_OVERFLOW_EN` defined: the signed-overflow logic is built. `o_overflow` is updated on the final slice as described in Operation.
- `SERIAL_SUB_OVERFLOW_EN` not defined: the overflow logic is omitted. The `o_overflow` port remains and is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Plain subtract, WIDTH = 16: A = 0x1234, B = 0x0234, borrow-in = 0 → after 4 cycles `o_done` pulses; `o_result` = 0x1000, `o_borrow` = 0, `o_overflow` = 0.
- Underflow with wrap-around: A = 0x0000, B = 0x0001, borrow-in = 0 → `o_result` = 0xFFFF, `o_borrow` = 1, `o_overflow` = 0.
- Borrow-in rippling across slices: A = 0x0010, B = 0x0000, borrow-in = 1 → `o_result` = 0x000F, `o_borrow` = 0.
- Signed overflow, macro defined: A = 0x8000, B = 0x0001 → `o_result` = 0x7FFF, `o_overflow` = 1, `o_borrow` = 0. With the macro undefined the same stimulus gives `o_overflow` = 0.
- Handshake:
  - pulse `i_start` with A = 0x00FF, B = 0x000F
  - re-assert `i_start` with A = 0xFFFF, B = 0xFFFF in the second RUN cycle
  - required: the second request is ignored, the first result is 0x00F0, and `o_done` pulses exactly once
  - then hold `i_start` through DONE; required: the next operation is accepted on the following edge
- Reset mid-operation: assert `i_rst` during the third RUN cycle → all outputs are 0 immediately and state is IDLE; after release, a new request A = 0x0005, B = 0x0003 gives 0x0002 after 4 cycles.
